// File: rtl/noc_yummy_rx.sv
// Credit-based (yummy) NoC receive buffer: DEPTH-entry FIFO that returns one
// credit per popped flit and tracks header/body packet framing on the head.
module noc_yummy_rx #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              yummy_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              ready_i,
   output logic              sop_o,
   output logic              eop_o,
   output logic [15:0]       pkt_count_o,
   output logic              overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      HDR  = 1'b0,
      BODY = 1'b1
   } frame_state_e;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [7:0]        len;

   frame_state_e      state_q;
   frame_state_e      state_d;
   logic [7:0]        rem_q;
   logic [7:0]        rem_d;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Head is hidden while reset is asserted so nothing can be popped (or credited) at a reset edge.
   assign valid_o = !empty && !rst_i;
   assign pop     = valid_o && ready_i;
   assign push    = valid_i && !rst_i && (!full || pop);
   assign data_o  = mem[rd_ptr];
   assign len     = data_o[29:22];

   // NOTE: storage is deliberately not reset; occupancy alone decides whether an entry is meaningful.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_o  <= 1'b0;
         yummy_o     <= 1'b0;
         pkt_count_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (valid_i && full && !pop) overflow_o <= 1'b1;
         yummy_o <= pop;
         if (pop && eop_o) pkt_count_o <= pkt_count_o + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= HDR;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sop_o   = 1'b0;
      eop_o   = 1'b0;
      case (state_q)
         HDR: begin
            sop_o = valid_o;
            eop_o = valid_o && (len == 8'd0);
            if (pop && (len != 8'd0)) begin
               rem_d   = len;
               state_d = BODY;
            end
         end
         BODY: begin
            eop_o = valid_o && (rem_q == 8'd1);
            if (pop) begin
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase
   end

endmodule

// File: tb/tb_noc_yummy_rx.sv
// Randomized and directed bench for noc_yummy_rx against a queue-based packet model.
module tb_noc_yummy_rx;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              valid_i = 1'b0;
   logic [DATA_W-1:0] data_i = '0;
   logic              ready_i = 1'b0;
   logic              yummy_o;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic              sop_o;
   logic              eop_o;
   logic [15:0]       pkt_count_o;
   logic              overflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   noc_yummy_rx #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .yummy_o     (yummy_o),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .ready_i     (ready_i),
      .sop_o       (sop_o),
      .eop_o       (eop_o),
      .pkt_count_o (pkt_count_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: buffered flits, body flits left in the current packet, counters.
   logic [DATA_W-1:0] mq[$];
   int                m_left  = 0;
   logic [15:0]       m_pkt   = '0;
   bit                m_ovf   = 1'b0;
   bit                m_yummy = 1'b0;

   function automatic logic [DATA_W-1:0] mk_flit(input logic [7:0] len);
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom};
      d[29:22] = len;
      return d;
   endfunction

   function automatic logic [7:0] head_len();
      logic [DATA_W-1:0] h;
      h = mq[0];
      return h[29:22];
   endfunction

   function automatic bit exp_valid();
      return (mq.size() != 0) && !rst_i;
   endfunction

   function automatic bit exp_sop();
      return exp_valid() && (m_left == 0);
   endfunction

   function automatic bit exp_eop();
      if (!exp_valid()) return 1'b0;
      return (m_left == 0) ? (head_len() == 8'd0) : (m_left == 1);
   endfunction

   task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit rst);
      bit was_full;
      bit pop;
      bit last;
      if (rst) begin
         mq.delete();
         m_left  = 0;
         m_pkt   = '0;
         m_ovf   = 1'b0;
         m_yummy = 1'b0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() != 0) && r;
         last     = exp_eop();
         if (pop) begin
            if (m_left == 0) m_left = int'(head_len());
            else             m_left = m_left - 1;
            if (last) m_pkt = m_pkt + 16'd1;
            void'(mq.pop_front());
         end
         m_yummy = pop;
         if (v) begin
            if (!was_full || pop) mq.push_back(d);
            else                  m_ovf = 1'b1;
         end
      end
   endtask

   // One clock: drive inputs, advance DUT and model on the edge, sample 1 time unit later.
   task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
      valid_i = v;
      data_i  = d;
      ready_i = r;
      @(posedge clk_i);
      model_edge(v, d, r, rst_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step(1'b0, '0, 1'b0);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step(1'b1, mk_flit(8'd0), 1'b1);
      step(1'b1, mk_flit(8'd0), 1'b1);
      n_checks++;
      if ({valid_o, sop_o, eop_o, yummy_o, overflow_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000", {valid_o, sop_o, eop_o, yummy_o, overflow_o});
      end
      n_checks++;
      if (pkt_count_o !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_pkt: got %0d want 0", pkt_count_o);
      end
      rst_i = 1'b0;
      step(1'b0, '0, 1'b1);
      n_checks++;
      if ({valid_o, sop_o, eop_o} !== 3'b0) begin
         n_fail++;
         $display("FAIL reset_after: got %b want 000 (flits during reset ignored)", {valid_o, sop_o, eop_o});
      end
   endtask

   task automatic test_single_flit();
      logic [DATA_W-1:0] h;
      do_reset();
      h = mk_flit(8'd0);
      step(1'b1, h, 1'b1);
      n_checks++;
      if ({valid_o, sop_o, eop_o, yummy_o} !== 4'b1110 || data_o !== h) begin
         n_fail++;
         $display("FAIL single_head: got v/s/e/y=%b data=%h want 1110 data=%h",
                  {valid_o, sop_o, eop_o, yummy_o}, data_o, h);
      end
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (yummy_o !== 1'b1 || pkt_count_o !== 16'd1 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: got yummy=%b pkt=%0d valid=%b want 1 1 0", yummy_o, pkt_count_o, valid_o);
      end
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (yummy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_yummy_once: got %b want 0", yummy_o);
      end
   endtask

   task automatic test_three_flit();
      logic [DATA_W-1:0] f [3];
      int ys;
      do_reset();
      f[0] = mk_flit(8'd2);
      f[1] = mk_flit(8'($urandom));
      f[2] = mk_flit(8'($urandom));
      ys = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, f[i], 1'b1);
         ys += int'(yummy_o);
         n_checks++;
         if (data_o !== f[i] || sop_o !== (i == 0) || eop_o !== (i == 2) || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL three_flit_%0d: got data=%h sop=%b eop=%b valid=%b want data=%h sop=%b eop=%b",
                     i, data_o, sop_o, eop_o, valid_o, f[i], (i == 0), (i == 2));
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1);
         ys += int'(yummy_o);
      end
      n_checks++;
      if (ys != 3 || pkt_count_o !== 16'd1) begin
         n_fail++;
         $display("FAIL three_flit_totals: got yummies=%0d pkt=%0d want 3 1", ys, pkt_count_o);
      end
   endtask

   task automatic test_fill_overflow();
      logic [DATA_W-1:0] f [5];
      int ys;
      do_reset();
      for (int i = 0; i < 5; i++) f[i] = mk_flit(8'($urandom));
      for (int i = 0; i < 4; i++) step(1'b1, f[i], 1'b0);
      n_checks++;
      if (overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_no_overflow: got %b want 0", overflow_o);
      end
      step(1'b1, f[4], 1'b0);
      n_checks++;
      if (overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_overflow: got %b want 1", overflow_o);
      end
      ys = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (valid_o !== 1'b1 || data_o !== f[i]) begin
            n_fail++;
            $display("FAIL fill_drain_%0d: got valid=%b data=%h want 1 %h", i, valid_o, data_o, f[i]);
         end
         step(1'b0, '0, 1'b1);
         ys += int'(yummy_o);
      end
      step(1'b0, '0, 1'b1);
      ys += int'(yummy_o);
      n_checks++;
      if (valid_o !== 1'b0 || ys != 4 || overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_end: got valid=%b yummies=%0d overflow=%b want 0 4 1", valid_o, ys, overflow_o);
      end
   endtask

   task automatic test_full_push_pop();
      logic [DATA_W-1:0] f [5];
      do_reset();
      for (int i = 0; i < 5; i++) f[i] = mk_flit(8'($urandom));
      for (int i = 0; i < 4; i++) step(1'b1, f[i], 1'b0);
      step(1'b1, f[4], 1'b1);
      n_checks++;
      if (overflow_o !== 1'b0 || yummy_o !== 1'b1 || valid_o !== 1'b1 || data_o !== f[1]) begin
         n_fail++;
         $display("FAIL full_pushpop: got ovf=%b yummy=%b valid=%b data=%h want 0 1 1 %h",
                  overflow_o, yummy_o, valid_o, data_o, f[1]);
      end
      for (int i = 1; i < 5; i++) begin
         n_checks++;
         if (valid_o !== 1'b1 || data_o !== f[i]) begin
            n_fail++;
            $display("FAIL full_drain_%0d: got valid=%b data=%h want 1 %h", i, valid_o, data_o, f[i]);
         end
         step(1'b0, '0, 1'b1);
      end
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_occupancy: got valid=%b want 0 after 4 pops", valid_o);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      step(1'b1, mk_flit(8'd3), 1'b1);
      step(1'b1, mk_flit(8'($urandom)), 1'b1);
      step(1'b1, mk_flit(8'($urandom)), 1'b1);
      step(1'b1, mk_flit(8'($urandom)), 1'b0);
      n_checks++;
      if (valid_o !== 1'b1 || sop_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midpkt_setup: got valid=%b sop=%b want 1 0", valid_o, sop_o);
      end
      rst_i = 1'b1;
      step(1'b1, mk_flit(8'd0), 1'b1);
      rst_i = 1'b0;
      n_checks++;
      if (valid_o !== 1'b0 || yummy_o !== 1'b0 || pkt_count_o !== 16'd0) begin
         n_fail++;
         $display("FAIL midpkt_reset: got valid=%b yummy=%b pkt=%0d want 0 0 0", valid_o, yummy_o, pkt_count_o);
      end
      step(1'b1, mk_flit(8'd5), 1'b0);
      n_checks++;
      if ({valid_o, sop_o, eop_o, yummy_o} !== 4'b1100) begin
         n_fail++;
         $display("FAIL midpkt_new_header: got v/s/e/y=%b want 1100", {valid_o, sop_o, eop_o, yummy_o});
      end
   endtask

   task automatic test_random();
      bit v;
      bit r;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         v = ($urandom % 100) < 60;
         r = ($urandom % 100) < 55;
         step(v, mk_flit(8'($urandom_range(0, 3))), r);
         n_checks++;
         if ({valid_o, sop_o, eop_o} !== {exp_valid(), exp_sop(), exp_eop()}) begin
            n_fail++;
            $display("FAIL rand_frame c=%0d: got v/s/e=%b want %b", c,
                     {valid_o, sop_o, eop_o}, {exp_valid(), exp_sop(), exp_eop()});
         end
         n_checks++;
         if (yummy_o !== m_yummy || overflow_o !== m_ovf || pkt_count_o !== m_pkt) begin
            n_fail++;
            $display("FAIL rand_state c=%0d: got yummy=%b ovf=%b pkt=%0d want %b %b %0d",
                     c, yummy_o, overflow_o, pkt_count_o, m_yummy, m_ovf, m_pkt);
         end
         if (exp_valid()) begin
            n_checks++;
            if (data_o !== mq[0]) begin
               n_fail++;
               $display("FAIL rand_data c=%0d: got %h want %h", c, data_o, mq[0]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] h;
      do_reset();
      h = mk_flit(8'd0);
      for (int i = 0; i < 65536; i++) step(1'b1, h, 1'b1);
      n_checks++;
      if (pkt_count_o !== 16'hFFFF || pkt_count_o !== m_pkt) begin
         n_fail++;
         $display("FAIL wrap_pre: got %0d want 65535 (model %0d)", pkt_count_o, m_pkt);
      end
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (pkt_count_o !== 16'd0 || overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap: got pkt=%0d ovf=%b want 0 0", pkt_count_o, overflow_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_flit();
      test_three_flit();
      test_fill_overflow();
      test_full_push_pop();
      test_reset_mid_packet();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
